// File: rtl/prog_mem_pkg.sv
// Shared definitions for the loadable program memory: default encodings,
// controller state and the length-counter width helper.
package prog_mem_pkg;

   localparam int unsigned INSTR_W_DEF = 18;
   localparam logic [INSTR_W_DEF-1:0] NOP_INSTR_DEF = '0;

   typedef enum logic {
      ST_LOAD = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   // Width needed to hold a word count in the range 0..depth inclusive.
   function automatic int unsigned len_w(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/prog_mem_array.sv
// DEPTH x W storage with one synchronous write port and one synchronous,
// read-enabled read port; no reset so it maps onto block RAM.
module prog_mem_array #(
   parameter int unsigned W     = 18,
   parameter int unsigned DEPTH = 256,
   parameter int unsigned AW    = 8
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem [DEPTH];
   logic [W-1:0] rdata_q;

   // Read data holds between enabled reads so the fetched word stays stable.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata_q <= mem[raddr];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/program_ram.sv
// Loadable program memory: bootloader streams words in during LOAD, the fetch
// stage reads them with one-cycle latency in RUN; out-of-range fetches fault.
module program_ram import prog_mem_pkg::*; #(
   parameter int unsigned        INSTR_W   = INSTR_W_DEF,
   parameter int unsigned        ADDR_W    = 16,
   parameter int unsigned        DEPTH     = 256,
   parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEF)
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic                      i_ld_valid,
   input  logic [INSTR_W-1:0]        i_ld_data,
   input  logic                      i_ld_last,
   output logic                      o_ld_ready,
   input  logic                      i_reload,
   input  logic                      i_fetch_req,
   input  logic [ADDR_W-1:0]         i_fetch_addr,
   output logic [INSTR_W-1:0]        o_instr,
   output logic                      o_instr_valid,
   output logic                      o_fault,
   output logic                      o_run,
   output logic [len_w(DEPTH)-1:0]   o_prog_len
);

   localparam int unsigned LEN_W = len_w(DEPTH);
   localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CMP_W = (ADDR_W > LEN_W) ? ADDR_W : LEN_W;

   state_e             state_q, state_d;
   logic [AW-1:0]      ld_ptr_q, ld_ptr_d;
   logic [LEN_W-1:0]   prog_len_q, prog_len_d;
   logic               valid_q, valid_d;
   logic               fault_q, fault_d;
   logic               nop_sel_q, nop_sel_d;
   logic               we_c, re_c, oor_c;
   logic [INSTR_W-1:0] rd_data;

   always_comb begin
      state_d    = state_q;
      ld_ptr_d   = ld_ptr_q;
      prog_len_d = prog_len_q;
      valid_d    = 1'b0;
      fault_d    = 1'b0;
      nop_sel_d  = nop_sel_q;
      we_c       = 1'b0;
      re_c       = 1'b0;
      oor_c      = CMP_W'(i_fetch_addr) >= CMP_W'(prog_len_q);

      case (state_q)
         ST_LOAD: begin
            if (i_ld_valid) begin
               we_c       = 1'b1;
               ld_ptr_d   = ld_ptr_q + AW'(1);
               prog_len_d = prog_len_q + LEN_W'(1);
               if (i_ld_last || (ld_ptr_q == AW'(DEPTH - 1))) state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            // The out-of-range flag is registered with the read so the NOP mux
            // lines up with the RAM output a cycle later.
            if (i_fetch_req) begin
               re_c      = 1'b1;
               valid_d   = 1'b1;
               fault_d   = oor_c;
               nop_sel_d = oor_c;
            end
            if (i_reload) begin
               state_d    = ST_LOAD;
               ld_ptr_d   = '0;
               prog_len_d = '0;
            end
         end
         default: state_d = ST_LOAD;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= ST_LOAD;
         ld_ptr_q   <= '0;
         prog_len_q <= '0;
         valid_q    <= 1'b0;
         fault_q    <= 1'b0;
         nop_sel_q  <= 1'b1;
      end else begin
         state_q    <= state_d;
         ld_ptr_q   <= ld_ptr_d;
         prog_len_q <= prog_len_d;
         valid_q    <= valid_d;
         fault_q    <= fault_d;
         nop_sel_q  <= nop_sel_d;
      end
   end

   prog_mem_array #(
      .W     (INSTR_W),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk   (i_clk),
      .we    (we_c),
      .waddr (ld_ptr_q),
      .wdata (i_ld_data),
      .re    (re_c),
      .raddr (i_fetch_addr[AW-1:0]),
      .rdata (rd_data)
   );

   assign o_instr       = nop_sel_q ? NOP_INSTR : rd_data;
   assign o_instr_valid = valid_q;
   assign o_fault       = fault_q;
   assign o_run         = (state_q == ST_RUN);
   assign o_ld_ready    = (state_q == ST_LOAD);
   assign o_prog_len    = prog_len_q;

endmodule

// File: tb/tb_program_ram.sv
// Directed, table-driven check of program_ram: boot, fetch, range faults,
// reload, depth limit and asynchronous reset.
module tb_program_ram;

   logic        clk;
   logic        rst_n;
   logic        ld_valid, ld_last, reload, fetch_req;
   logic [17:0] ld_data;
   logic [15:0] fetch_addr;
   logic [17:0] instr;
   logic        instr_valid, fault, run, ld_ready;
   logic [8:0]  prog_len;

   logic        d4_ld_valid, d4_ld_last, d4_reload, d4_fetch_req;
   logic [17:0] d4_ld_data;
   logic [15:0] d4_fetch_addr;
   logic [17:0] d4_instr;
   logic        d4_instr_valid, d4_fault, d4_run, d4_ld_ready;
   logic [2:0]  d4_prog_len;

   int n_checks = 0;
   int n_fail   = 0;

   program_ram dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_ld_valid(ld_valid), .i_ld_data(ld_data), .i_ld_last(ld_last),
      .o_ld_ready(ld_ready), .i_reload(reload),
      .i_fetch_req(fetch_req), .i_fetch_addr(fetch_addr),
      .o_instr(instr), .o_instr_valid(instr_valid), .o_fault(fault),
      .o_run(run), .o_prog_len(prog_len)
   );

   program_ram #(.DEPTH(4)) dut4 (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_ld_valid(d4_ld_valid), .i_ld_data(d4_ld_data), .i_ld_last(d4_ld_last),
      .o_ld_ready(d4_ld_ready), .i_reload(d4_reload),
      .i_fetch_req(d4_fetch_req), .i_fetch_addr(d4_fetch_addr),
      .o_instr(d4_instr), .o_instr_valid(d4_instr_valid), .o_fault(d4_fault),
      .o_run(d4_run), .o_prog_len(d4_prog_len)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        f;
      logic [15:0] a;
      logic [17:0] ei;
      logic        ev;
      logic        ef;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc(input logic v, input logic [17:0] d, input logic last,
                      input logic rl, input logic f, input logic [15:0] a);
      @(negedge clk);
      ld_valid = v; ld_data = d; ld_last = last; reload = rl;
      fetch_req = f; fetch_addr = a;
      @(posedge clk);
      #1;
   endtask

   task automatic cyc4(input logic v, input logic [17:0] d, input logic f,
                       input logic [15:0] a);
      @(negedge clk);
      d4_ld_valid = v; d4_ld_data = d; d4_ld_last = 1'b0;
      d4_fetch_req = f; d4_fetch_addr = a;
      @(posedge clk);
      #1;
   endtask

   logic [17:0] words [6];
   logic [17:0] w4 [4];
   vec_t        vecs [13];

   initial begin
      words = '{18'h00081, 18'h32800, 18'h31000, 18'h0007F, 18'h3A400, 18'h31000};
      w4    = '{18'h12345, 18'h23456, 18'h34567, 18'h01234};
      vecs  = '{
         '{1'b1, 16'd0,     18'h00081, 1'b1, 1'b0},
         '{1'b1, 16'd1,     18'h32800, 1'b1, 1'b0},
         '{1'b1, 16'd2,     18'h31000, 1'b1, 1'b0},
         '{1'b1, 16'd3,     18'h0007F, 1'b1, 1'b0},
         '{1'b1, 16'd4,     18'h3A400, 1'b1, 1'b0},
         '{1'b1, 16'd5,     18'h31000, 1'b1, 1'b0},
         '{1'b1, 16'd6,     18'h00000, 1'b1, 1'b1},
         '{1'b1, 16'hFFFF,  18'h00000, 1'b1, 1'b1},
         '{1'b0, 16'd0,     18'h00000, 1'b0, 1'b0},
         '{1'b1, 16'd3,     18'h0007F, 1'b1, 1'b0},
         '{1'b0, 16'd5,     18'h0007F, 1'b0, 1'b0},
         '{1'b1, 16'h0100,  18'h00000, 1'b1, 1'b1},
         '{1'b1, 16'd5,     18'h31000, 1'b1, 1'b0}
      };

      rst_n = 1'b0;
      ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0; reload = 1'b0;
      fetch_req = 1'b0; fetch_addr = '0;
      d4_ld_valid = 1'b0; d4_ld_data = '0; d4_ld_last = 1'b0; d4_reload = 1'b0;
      d4_fetch_req = 1'b0; d4_fetch_addr = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_instr", 32'(instr), 32'h0);
      check("rst_valid", 32'(instr_valid), 32'h0);
      check("rst_fault", 32'(fault), 32'h0);
      check("rst_run", 32'(run), 32'h0);
      check("rst_ld_ready", 32'(ld_ready), 32'h1);
      check("rst_prog_len", 32'(prog_len), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Boot: fetch on the final word and reload mid-load must both be ignored.
      for (int i = 0; i < 6; i++) begin
         cyc(1'b1, words[i], i == 5, i == 2, i == 5, 16'd0);
         if (i == 4) begin
            check("boot_run_before_last", 32'(run), 32'h0);
            check("boot_len5", 32'(prog_len), 32'd5);
         end
      end
      check("boot_len6", 32'(prog_len), 32'd6);
      check("boot_run", 32'(run), 32'h1);
      check("boot_ld_ready", 32'(ld_ready), 32'h0);
      check("boot_last_fetch_ignored", 32'(instr_valid), 32'h0);

      cyc(1'b1, 18'h3FFFF, 1'b1, 1'b0, 1'b0, 16'd0);
      check("run_ld_ignored_len", 32'(prog_len), 32'd6);
      check("run_ld_ignored_run", 32'(run), 32'h1);

      foreach (vecs[i]) begin
         cyc(1'b0, 18'h0, 1'b0, 1'b0, vecs[i].f, vecs[i].a);
         check($sformatf("vec%0d_instr", i), 32'(instr), 32'(vecs[i].ei));
         check($sformatf("vec%0d_valid", i), 32'(instr_valid), 32'(vecs[i].ev));
         check($sformatf("vec%0d_fault", i), 32'(fault), 32'(vecs[i].ef));
      end

      // Reload with a concurrent fetch: fetch completes, state already LOAD.
      cyc(1'b0, 18'h0, 1'b0, 1'b1, 1'b1, 16'd2);
      check("reload_instr", 32'(instr), 32'h31000);
      check("reload_valid", 32'(instr_valid), 32'h1);
      check("reload_fault", 32'(fault), 32'h0);
      check("reload_run", 32'(run), 32'h0);
      check("reload_len", 32'(prog_len), 32'h0);
      check("reload_ld_ready", 32'(ld_ready), 32'h1);

      cyc(1'b0, 18'h0, 1'b1, 1'b0, 1'b1, 16'd0);
      check("last_no_valid_run", 32'(run), 32'h0);
      check("last_no_valid_len", 32'(prog_len), 32'h0);
      check("load_fetch_ignored_valid", 32'(instr_valid), 32'h0);
      check("load_fetch_ignored_fault", 32'(fault), 32'h0);
      check("load_instr_hold", 32'(instr), 32'h31000);

      cyc(1'b1, 18'h11111, 1'b0, 1'b0, 1'b0, 16'd0);
      cyc(1'b1, 18'h22222, 1'b1, 1'b0, 1'b0, 16'd0);
      check("reload2_len", 32'(prog_len), 32'd2);
      check("reload2_run", 32'(run), 32'h1);
      cyc(1'b0, 18'h0, 1'b0, 1'b0, 1'b1, 16'd3);
      check("reload2_a3_fault", 32'(fault), 32'h1);
      check("reload2_a3_instr", 32'(instr), 32'h0);
      check("reload2_a3_valid", 32'(instr_valid), 32'h1);
      cyc(1'b0, 18'h0, 1'b0, 1'b0, 1'b1, 16'd0);
      check("reload2_a0", 32'(instr), 32'h11111);
      cyc(1'b0, 18'h0, 1'b0, 1'b0, 1'b1, 16'd1);
      check("reload2_a1", 32'(instr), 32'h22222);
      cyc(1'b0, 18'h0, 1'b0, 1'b1, 1'b0, 16'd0);

      // Asynchronous reset between edges after three loaded words.
      cyc(1'b1, 18'h0AAAA, 1'b0, 1'b0, 1'b0, 16'd0);
      cyc(1'b1, 18'h0BBBB, 1'b0, 1'b0, 1'b0, 16'd0);
      cyc(1'b1, 18'h0CCCC, 1'b0, 1'b0, 1'b0, 16'd0);
      check("midload_len3", 32'(prog_len), 32'd3);
      #1;
      rst_n = 1'b0;
      #1;
      check("async_rst_len", 32'(prog_len), 32'h0);
      check("async_rst_instr", 32'(instr), 32'h0);
      check("async_rst_ld_ready", 32'(ld_ready), 32'h1);
      check("async_rst_run", 32'(run), 32'h0);
      cyc(1'b0, 18'h0, 1'b0, 1'b0, 1'b0, 16'd0);
      @(negedge clk);
      rst_n = 1'b1;
      cyc(1'b1, 18'h3FFFF, 1'b1, 1'b0, 1'b0, 16'd0);
      check("post_rst_len", 32'(prog_len), 32'd1);
      check("post_rst_run", 32'(run), 32'h1);
      cyc(1'b0, 18'h0, 1'b0, 1'b0, 1'b1, 16'd0);
      check("post_rst_a0", 32'(instr), 32'h3FFFF);
      cyc(1'b0, 18'h0, 1'b0, 1'b0, 1'b1, 16'd1);
      check("post_rst_a1_fault", 32'(fault), 32'h1);
      cyc(1'b0, 18'h0, 1'b0, 1'b0, 1'b0, 16'd0);

      // Depth limit on the DEPTH=4 instance.
      for (int i = 0; i < 4; i++) begin
         cyc4(1'b1, w4[i], 1'b0, 16'd0);
         if (i == 2) begin
            check("d4_run_before_full", 32'(d4_run), 32'h0);
            check("d4_len3", 32'(d4_prog_len), 32'd3);
         end
      end
      check("d4_run", 32'(d4_run), 32'h1);
      check("d4_len4", 32'(d4_prog_len), 32'd4);
      check("d4_ld_ready", 32'(d4_ld_ready), 32'h0);
      cyc4(1'b1, 18'h3FFFF, 1'b0, 16'd0);
      check("d4_fifth_len", 32'(d4_prog_len), 32'd4);
      cyc4(1'b0, 18'h0, 1'b1, 16'd3);
      check("d4_a3", 32'(d4_instr), 32'h01234);
      check("d4_a3_fault", 32'(d4_fault), 32'h0);
      cyc4(1'b0, 18'h0, 1'b1, 16'd4);
      check("d4_a4_fault", 32'(d4_fault), 32'h1);
      check("d4_a4_instr", 32'(d4_instr), 32'h0);
      cyc4(1'b0, 18'h0, 1'b1, 16'd0);
      check("d4_a0", 32'(d4_instr), 32'h12345);
      cyc4(1'b0, 18'h0, 1'b0, 16'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/program_ram.md
# program_ram

Parametrised, loadable program memory: the successor to the fixed combinational program ROM. A bootloader streams instruction words in, a fixed number of addresses per word. Once loading ends, the CPU fetch stage reads instructions with one-cycle registered latency. Addresses beyond the loaded program length return a NOP and raise a fault. Sits between the boot/debug loader and the CPU fetch stage.

## Interface
- `INSTR_W`, 18: instruction width in bits.
- `ADDR_W`, 16: fetch address width in bits.
- `DEPTH`, 256: number of words. Constraint: 1 ≤ DEPTH ≤ 2^ADDR_W.
- `NOP_INSTR`, 18'h00000: word returned on faulted fetch and at reset.
- `i_clk`  in  1  the single clock.
- `i_rst_n`  in  1  reset, asynchronous and active-low.
- `i_ld_valid`  in  1  load word present.
- `i_ld_data`  in  INSTR_W  load word.
- `i_ld_last`  in  1  qualifies the final load word.
- `o_ld_ready`  out  1  high while in LOAD.
- `i_reload`  in  1  single-cycle request to return to LOAD.
- `i_fetch_req`  in  1  fetch strobe.
- `i_fetch_addr`  in  ADDR_W  fetch address.
- `o_instr`  out  INSTR_W  fetched instruction.
- `o_instr_valid`  out  1  o_instr updated this cycle.
- `o_fault`  out  1  fetch address was ≥ program length (one-cycle pulse).
- `o_run`  out  1  high while in RUN.
- `o_prog_len`  out  LEN_W  number of loaded words, where LEN_W = $clog2(DEPTH+1).

## Operation
States:
- **LOAD**, entered from reset.
  - `o_ld_ready` = 1.
  - Each cycle with `i_ld_valid` writes `i_ld_data` at address `ld_ptr` and increments both `ld_ptr` and `o_prog_len`.
  - Go to RUN after the accepted word when either `i_ld_last` is set or `ld_ptr` reaches DEPTH−1.
  - Fetches in LOAD are ignored: no valid, no fault.
  - `i_reload` is ignored in LOAD.
- **RUN**.
  - `o_ld_ready` = 0 and `i_ld_valid` is ignored.
  - If `i_fetch_req` is set and `i_fetch_addr < o_prog_len`, the next cycle has `o_instr` = mem[addr] and `o_instr_valid` = 1.
  - If the address is out of range, the next cycle has `o_instr` = NOP_INSTR, `o_instr_valid` = 1 and `o_fault` = 1.
  - `i_reload` moves to LOAD next cycle and clears `ld_ptr` and `o_prog_len` to 0. Memory contents are retained.
- The fetch comparison is unsigned and zero-extends to max(ADDR_W, LEN_W).
- `o_instr` holds its last value when no fetch completes. `o_instr_valid` and `o_fault` are single-cycle pulses.
- Zero-length program (empty load, e.g. after `i_reload` with no subsequent `i_ld_valid`): stays in LOAD. `i_ld_last` without `i_ld_valid` has no effect.

## Timing
- Reset values:
  - state = LOAD, `ld_ptr` = 0, `o_prog_len` = 0, `o_instr` = NOP_INSTR.
  - `o_instr_valid` = 0, `o_fault` = 0, `o_run` = 0, `o_ld_ready` = 1.
  - Memory array is not reset.
- Load write is accepted on the rising edge where `i_ld_valid` && `o_ld_ready`.
- `o_run` rises the cycle after the final accepted word. A fetch issued in that same final-word cycle is ignored.
- Fetch latency is 1 cycle. Back-to-back requests sustain one instruction per cycle.
- `i_reload` together with `i_fetch_req` in the same RUN cycle: the fetch completes normally next cycle, and the state is LOAD from that cycle on.
- `o_run` and `o_ld_ready` are decoded from the registered state, not from inputs.
- Asserting reset mid-load or mid-fetch immediately forces all reset values. Any pending fetch result is discarded.

## Structure
- Shared package `prog_mem_pkg`:
  - default INSTR_W, NOP_INSTR encoding;
  - state enum {LOAD, RUN};
  - `LEN_W` helper function.
- Sub-module `prog_mem_array`: DEPTH×INSTR_W memory with one synchronous write port and one synchronous read port, no reset, inferable as block RAM.
- Top level `program_ram`: holds the FSM, `ld_ptr`/length counters, range check, and NOP/fault output muxing.
- Out-of-range detection is registered alongside the read address so the NOP mux aligns with the RAM output.

## Test plan
- **Reset and boot:** reset, then stream 18'h00081, 18'h32800, 18'h31000, 18'h0007F, 18'h3A400, 18'h31000 with `i_ld_last` on the sixth word. Required: `o_prog_len` = 6, and `o_run` = 1 one cycle later.
- **Fetch:** after boot, fetch addresses 0..5 back-to-back. Required: `o_instr` returns those six words in order, one per cycle, `o_instr_valid` high for 6 cycles, `o_fault` never set.
- **Out of range:** fetch address 6 and address 16'hFFFF. Required: `o_instr` = 18'h00000, `o_fault` = 1, `o_instr_valid` = 1 on each.
- **Depth limit:** DEPTH = 4, stream 4 words without `i_ld_last`. Required: RUN after the 4th word, `o_prog_len` = 4, and a 5th `i_ld_valid` is not accepted.
- **Reload:** `i_reload` together with a fetch of address 2. Required: the next cycle returns word 2 with `o_run` = 0 and `o_prog_len` = 0. After a 2-word reload, fetching address 3 faults.
- **Async reset mid-load:** assert `i_rst_n` low between clock edges after 3 words. Required: outputs reach reset values immediately, without waiting for an edge, and the next load writes address 0.
